// File: rtl/seq_detector_param_if.sv
// rtl/seq_detector_param_if.sv - serial, config and match-result bundle for seq_detector_param
//
// Purpose: groups the serial input, configuration and match-result signals of
//          seq_detector_param so that they can be passed around as one port.
// Config macro: SEQDET_MASK_EN adds pat_mask (per-bit don't-care mask).
// Signals:
//   si, si_valid                  serial bit and its qualifier
//   cfg_load, pattern, pat_len,
//   overlap_en, pat_mask          configuration capture
//   clear                         synchronous flush
//   detected, match_count,
//   count_sat                     match results
// Modports: master drives stimulus and config; slave is the detector.
interface seq_detector_param_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
);
  logic               si;
  logic               si_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   pat_len;
  logic               overlap_en;
  logic               clear;
`ifdef SEQDET_MASK_EN
  logic [MAX_LEN-1:0] pat_mask;
`endif
  logic               detected;
  logic [CNT_W-1:0]   match_count;
  logic               count_sat;

`ifdef SEQDET_MASK_EN
  modport master (
    output si, si_valid, cfg_load, pattern, pat_len, overlap_en, clear, pat_mask,
    input  detected, match_count, count_sat
  );
  modport slave (
    input  si, si_valid, cfg_load, pattern, pat_len, overlap_en, clear, pat_mask,
    output detected, match_count, count_sat
  );
`else
  modport master (
    output si, si_valid, cfg_load, pattern, pat_len, overlap_en, clear,
    input  detected, match_count, count_sat
  );
  modport slave (
    input  si, si_valid, cfg_load, pattern, pat_len, overlap_en, clear,
    output detected, match_count, count_sat
  );
`endif
endinterface

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - runtime-programmable serial sequence detector
//
// Purpose: matches a programmable pattern of 1..MAX_LEN bits on a qualified
//          serial input, with overlapping or non-overlapping matching and a
//          saturating match counter.
// Config macro: SEQDET_MASK_EN enables the per-bit don't-care mask.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seq_detector_param_if.slave (si/si_valid in, config in,
//          detected/match_count/count_sat out)
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_detector_param_if.slave  bus
);

  logic [MAX_LEN-1:0] hist, hist_d;
  logic [LEN_W-1:0]   fill, fill_d;
  logic [MAX_LEN-1:0] cfg_pattern, cfg_pattern_d;
  logic [LEN_W-1:0]   cfg_len, cfg_len_d;
  logic               cfg_overlap, cfg_overlap_d;
  logic [MAX_LEN-1:0] cfg_mask, cfg_mask_d;
  logic               detected, detected_d;
  logic [CNT_W-1:0]   match_count, match_count_d;
  logic               count_sat, count_sat_d;

  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic [MAX_LEN-1:0] len_mask;
  logic [MAX_LEN-1:0] cmp_mask;
  logic               match;

  // Match is judged on the history as it will be after accepting this sample.
  always_comb begin
    hist_shift = {hist[MAX_LEN-2:0], bus.si};
    fill_inc   = (fill >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : fill + LEN_W'(1);
    len_mask   = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < cfg_len);
    end
    cmp_mask = len_mask & ~cfg_mask;
    match    = (cfg_len != '0) && (fill_inc >= cfg_len) &&
               (((hist_shift ^ cfg_pattern) & cmp_mask) == '0);
  end

  always_comb begin
    hist_d        = hist;
    fill_d        = fill;
    cfg_pattern_d = cfg_pattern;
    cfg_len_d     = cfg_len;
    cfg_overlap_d = cfg_overlap;
    cfg_mask_d    = cfg_mask;
    detected_d    = 1'b0;
    match_count_d = match_count;
    if (bus.clear) begin
      hist_d        = '0;
      fill_d        = '0;
      match_count_d = '0;
    end else if (bus.cfg_load) begin
      // Any sample arriving alongside a config load is dropped.
      cfg_pattern_d = bus.pattern;
      cfg_len_d     = (bus.pat_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.pat_len;
      cfg_overlap_d = bus.overlap_en;
`ifdef SEQDET_MASK_EN
      cfg_mask_d    = bus.pat_mask;
`endif
      hist_d        = '0;
      fill_d        = '0;
    end else if (bus.si_valid) begin
      hist_d = hist_shift;
      fill_d = (match && !cfg_overlap) ? '0 : fill_inc;
      if (match) begin
        detected_d = 1'b1;
        if (match_count != {CNT_W{1'b1}}) begin
          match_count_d = match_count + CNT_W'(1);
        end
      end
    end
    count_sat_d = &match_count_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist        <= '0;
      fill        <= '0;
      cfg_pattern <= '0;
      cfg_len     <= '0;
      cfg_overlap <= 1'b0;
      cfg_mask    <= '0;
      detected    <= 1'b0;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else begin
      hist        <= hist_d;
      fill        <= fill_d;
      cfg_pattern <= cfg_pattern_d;
      cfg_len     <= cfg_len_d;
      cfg_overlap <= cfg_overlap_d;
      cfg_mask    <= cfg_mask_d;
      detected    <= detected_d;
      match_count <= match_count_d;
      count_sat   <= count_sat_d;
    end
  end

  assign bus.detected    = detected;
  assign bus.match_count = match_count;
  assign bus.count_sat   = count_sat;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - self-checking bench for seq_detector_param
module tb_seq_detector_param;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic exp_qa[$];
  logic exp_qb[$];

  seq_detector_param_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) ifa ();
  seq_detector_param_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) ifb ();

  seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock on DUT a: drive at negedge, compare detected at the next negedge.
  task automatic cyc(input logic v, input logic b, input logic e);
    ifa.si_valid = v;
    ifa.si       = b;
    exp_qa.push_back(e);
    @(negedge clk);
    chk("det_a", ifa.detected, exp_qa.pop_front());
  endtask

  task automatic cyc_b(input logic v, input logic b, input logic e);
    ifb.si_valid = v;
    ifb.si       = b;
    exp_qb.push_back(e);
    @(negedge clk);
    chk("det_b", ifb.detected, exp_qb.pop_front());
  endtask

  // Sends n bits MSB first; exps holds the expected detected per bit.
  task automatic send(input int n, input logic [15:0] bits, input logic [15:0] exps);
    for (int i = n - 1; i >= 0; i--) cyc(1'b1, bits[i], exps[i]);
    ifa.si_valid = 1'b0;
  endtask

  // Config load with a valid sample in the same cycle; that sample must be dropped.
  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov);
    ifa.cfg_load   = 1'b1;
    ifa.pattern    = pat;
    ifa.pat_len    = len;
    ifa.overlap_en = ov;
    cyc(1'b1, 1'b1, 1'b0);
    ifa.cfg_load   = 1'b0;
    ifa.si_valid   = 1'b0;
    ifa.pattern    = 8'hA5;
    ifa.pat_len    = 4'd0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    ifa.si = 1'b0; ifa.si_valid = 1'b0; ifa.cfg_load = 1'b0; ifa.pattern = '0;
    ifa.pat_len = '0; ifa.overlap_en = 1'b0; ifa.clear = 1'b0;
    ifb.si = 1'b0; ifb.si_valid = 1'b0; ifb.cfg_load = 1'b0; ifb.pattern = '0;
    ifb.pat_len = '0; ifb.overlap_en = 1'b0; ifb.clear = 1'b0;
`ifdef SEQDET_MASK_EN
    ifa.pat_mask = '0;
    ifb.pat_mask = '0;
`endif
    @(negedge clk);
    @(negedge clk);
    chk("rst_det", ifa.detected, 0);
    chk("rst_cnt", ifa.match_count, 0);
    chk("rst_sat", ifa.count_sat, 0);
    rst_n = 1'b1;

    // No config loaded yet: pattern on the pins must not take effect.
    ifa.pattern = 8'b101; ifa.pat_len = 4'd3;
    send(3, 16'b101, 16'b000);
    chk("noload_cnt", ifa.match_count, 0);

    // Overlap mode, 101 in 10101.
    load(8'b101, 4'd3, 1'b1);
    send(5, 16'b10101, 16'b00101);
    chk("ovl_cnt", ifa.match_count, 2);

    // Non-overlap mode; count is kept across a load.
    load(8'b101, 4'd3, 1'b0);
    send(5, 16'b10101, 16'b00100);
    chk("novl_cnt", ifa.match_count, 3);

    // Full-width pattern, then pat_len clamped from 12 to 8.
    load(8'b11010010, 4'd8, 1'b1);
    send(9, 16'b011010010, 16'b000000001);
    chk("len8_cnt", ifa.match_count, 4);
    load(8'b11010010, 4'd12, 1'b1);
    send(9, 16'b011010010, 16'b000000001);
    chk("clamp_cnt", ifa.match_count, 5);

    // Valid gaps hold state and keep detected low.
    load(8'b101, 4'd3, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    ifa.si_valid = 1'b0;
    chk("gap_cnt", ifa.match_count, 6);

    // clear with the completing bit: no pulse, history flushed.
    send(2, 16'b10, 16'b00);
    ifa.clear = 1'b1;
    cyc(1'b1, 1'b1, 1'b0);
    ifa.clear = 1'b0;
    chk("clr_cnt", ifa.match_count, 0);
    send(3, 16'b101, 16'b001);
    chk("postclr_cnt", ifa.match_count, 1);
    chk("a_sat", ifa.count_sat, 0);

    // Saturation on a 2-bit counter.
    ifb.cfg_load = 1'b1; ifb.pattern = 8'b11; ifb.pat_len = 4'd2; ifb.overlap_en = 1'b1;
    cyc_b(1'b0, 1'b0, 1'b0);
    ifb.cfg_load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc_b(1'b1, 1'b1, (i != 0));
      chk("b_cnt", ifb.match_count, (i < 4) ? i : 3);
      chk("b_sat", ifb.count_sat, (i >= 3));
    end
    ifb.si_valid = 1'b0;
    ifb.clear = 1'b1;
    cyc_b(1'b0, 1'b0, 1'b0);
    ifb.clear = 1'b0;
    chk("b_clr_cnt", ifb.match_count, 0);
    chk("b_clr_sat", ifb.count_sat, 0);

    // Reset mid-pattern, reload, partial history must be gone.
    load(8'b101, 4'd3, 1'b1);
    send(2, 16'b10, 16'b00);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_cnt", ifa.match_count, 0);
    rst_n = 1'b1;
    load(8'b101, 4'd3, 1'b1);
    send(1, 16'b1, 16'b0);
    send(2, 16'b01, 16'b01);
    chk("mrst_after", ifa.match_count, 1);

`ifdef SEQDET_MASK_EN
    ifa.pat_mask = 8'b010;
    load(8'b101, 4'd3, 1'b0);
    ifa.pat_mask = 8'h00;
    send(3, 16'b111, 16'b001);
    send(3, 16'b101, 16'b001);
    chk("mask_cnt", ifa.match_count, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
